// File: rtl/dma_app_core.sv
// Application core for the PCIe DMA path: scratch/control register file,
// C2F stream checksum and an FSM-driven F2C counter/LFSR generator.
module dma_app_core #(
  parameter int unsigned CHAN_WIDTH   = 7,
  parameter int unsigned STREAM_WIDTH = 64,
  parameter bit          EN_SWAP      = 1'b0,
  parameter bit          CKSUM_XOR    = 1'b0,
  parameter logic [63:0] LFSR_SEED    = 64'h0123456789ABCDEF,
  parameter logic [31:0] ID_VALUE     = 32'hDA7A0002
) (
  input  logic                    pcieClk_in,
  input  logic                    reset_in,
  input  logic [CHAN_WIDTH-1:0]   cpuChan_in,
  input  logic [31:0]             cpuWrData_in,
  input  logic                    cpuWrValid_in,
  output logic                    cpuWrReady_out,
  output logic [31:0]             cpuRdData_out,
  output logic                    cpuRdValid_out,
  input  logic [STREAM_WIDTH-1:0] c2fData_in,
  input  logic                    c2fValid_in,
  output logic [STREAM_WIDTH-1:0] f2cData_out,
  output logic                    f2cValid_out,
  input  logic                    f2cReady_in,
  input  logic                    f2cReset_in
);

  localparam int unsigned N    = 1 << CHAN_WIDTH;
  localparam int unsigned NSCR = N - 8;
  localparam int unsigned SW   = STREAM_WIDTH;

  localparam logic [CHAN_WIDTH-1:0] CH_CTRL   = CHAN_WIDTH'(N - 8);
  localparam logic [CHAN_WIDTH-1:0] CH_LIMIT  = CHAN_WIDTH'(N - 7);
  localparam logic [CHAN_WIDTH-1:0] CH_SENT   = CHAN_WIDTH'(N - 6);
  localparam logic [CHAN_WIDTH-1:0] CH_COUNT  = CHAN_WIDTH'(N - 5);
  localparam logic [CHAN_WIDTH-1:0] CH_CK_LSW = CHAN_WIDTH'(N - 4);
  localparam logic [CHAN_WIDTH-1:0] CH_CK_MSW = CHAN_WIDTH'(N - 3);
  localparam logic [CHAN_WIDTH-1:0] CH_ID     = CHAN_WIDTH'(N - 2);
  localparam logic [CHAN_WIDTH-1:0] CH_STATUS = CHAN_WIDTH'(N - 1);

  localparam logic [63:0] LFSR_MASK64 = (STREAM_WIDTH == 64) ? 64'hD800_0000_0000_0000
                                                             : 64'h0000_0000_8020_0003;
  localparam logic [SW-1:0] LFSR_MASK = SW'(LFSR_MASK64);
  localparam logic [SW-1:0] LFSR_INIT = SW'(LFSR_SEED);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [31:0]   r_scratch [N];
  logic          r_en;
  logic          r_mode;
  logic [31:0]   r_limit;
  logic [31:0]   r_sent;
  logic [31:0]   r_c2f_count;
  logic [SW-1:0] r_cksum;
  logic [SW-1:0] r_lfsr;
  logic [31:0]   r_idx;
  logic [1:0]    r_state;
  logic          r_valid;

  logic          w_wr_ctrl;
  logic          w_clear;
  logic          w_hs;
  logic          w_last;
  logic [SW-1:0] w_lfsr_next;
  logic [SW-1:0] w_cksum_next;
  logic [63:0]   w_cksum64;
  logic [1:0]    w_state_next;
  logic [31:0]   w_rd;

  assign w_wr_ctrl    = cpuWrValid_in && (cpuChan_in == CH_CTRL);
  assign w_clear      = (w_wr_ctrl && cpuWrData_in[2]) || f2cReset_in;
  assign w_hs         = r_valid && f2cReady_in;
  assign w_last       = (r_limit != 32'd0) && ((r_sent + 32'd1) == r_limit);
  assign w_lfsr_next  = r_lfsr[0] ? ((r_lfsr >> 1) ^ LFSR_MASK) : (r_lfsr >> 1);
  assign w_cksum_next = CKSUM_XOR ? (r_cksum ^ c2fData_in) : (r_cksum + c2fData_in);
  assign w_cksum64    = 64'(r_cksum);

  // Scratch registers; channels in the control window never land here
  always_ff @(posedge pcieClk_in or posedge reset_in) begin
    if (reset_in) begin
      for (int i = 0; i < int'(N); i++) r_scratch[i] <= '0;
    end else if (cpuWrValid_in && (32'(cpuChan_in) < NSCR)) begin
      r_scratch[cpuChan_in] <= cpuWrData_in;
    end
  end

  always_ff @(posedge pcieClk_in or posedge reset_in) begin
    if (reset_in) begin
      r_en    <= 1'b0;
      r_mode  <= 1'b0;
      r_limit <= '0;
    end else if (cpuWrValid_in) begin
      if (cpuChan_in == CH_CTRL) begin
        r_en   <= cpuWrData_in[0];
        r_mode <= cpuWrData_in[1];
      end
      if (cpuChan_in == CH_LIMIT) r_limit <= cpuWrData_in;
    end
  end

  // Stream datapath: a clear overrides both the C2F word and any F2C handshake
  always_ff @(posedge pcieClk_in or posedge reset_in) begin
    if (reset_in) begin
      r_cksum     <= '0;
      r_c2f_count <= '0;
      r_sent      <= '0;
      r_idx       <= '0;
      r_lfsr      <= LFSR_INIT;
    end else if (w_clear) begin
      r_cksum     <= '0;
      r_c2f_count <= '0;
      r_sent      <= '0;
      r_idx       <= '0;
      r_lfsr      <= LFSR_INIT;
    end else begin
      if (c2fValid_in) begin
        r_cksum     <= w_cksum_next;
        r_c2f_count <= r_c2f_count + 32'd1;
      end
      if (w_hs) begin
        r_idx  <= r_idx + 32'd1;
        r_sent <= r_sent + 32'd1;
        r_lfsr <= w_lfsr_next;
      end
    end
  end

  always_ff @(posedge pcieClk_in or posedge reset_in) begin
    if (reset_in) begin
      r_state <= S_IDLE;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_valid <= (w_state_next == S_RUN);
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (f2cReset_in) begin
      w_state_next = r_en ? S_RUN : S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: if (r_en) w_state_next = S_RUN;
        S_RUN: begin
          if (!r_en)                w_state_next = S_IDLE;
          else if (w_hs && w_last)  w_state_next = S_DONE;
        end
        S_DONE: if (!r_en) w_state_next = S_IDLE;
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_rd = '0;
    if (32'(cpuChan_in) < NSCR) begin
      w_rd = r_scratch[cpuChan_in];
    end else begin
      case (cpuChan_in)
        CH_CTRL:   w_rd = {30'd0, r_mode, r_en};
        CH_LIMIT:  w_rd = r_limit;
        CH_SENT:   w_rd = r_sent;
        CH_COUNT:  w_rd = r_c2f_count;
        CH_CK_LSW: w_rd = w_cksum64[31:0];
        CH_CK_MSW: w_rd = (STREAM_WIDTH == 64) ? w_cksum64[63:32] : 32'd0;
        CH_ID:     w_rd = ID_VALUE;
        CH_STATUS: w_rd = {30'd0, r_state};
        default:   w_rd = '0;
      endcase
    end
  end

  assign cpuRdData_out  = EN_SWAP ? {w_rd[15:0], w_rd[31:16]} : w_rd;
  assign cpuWrReady_out = 1'b1;
  assign cpuRdValid_out = 1'b1;
  assign f2cData_out    = r_mode ? r_lfsr : SW'(r_idx);
  assign f2cValid_out   = r_valid;

endmodule

// File: tb/tb_dma_app_core.sv
// Bench for dma_app_core: default instance plus a swap/XOR-checksum instance
// driven in parallel, checked against vector tables and a reference model.
module tb_dma_app_core;

  localparam logic [63:0] SEED   = 64'h0123456789ABCDEF;
  localparam logic [6:0]  CH_CTRL   = 7'd120;
  localparam logic [6:0]  CH_LIMIT  = 7'd121;
  localparam logic [6:0]  CH_SENT   = 7'd122;
  localparam logic [6:0]  CH_COUNT  = 7'd123;
  localparam logic [6:0]  CH_LSW    = 7'd124;
  localparam logic [6:0]  CH_MSW    = 7'd125;
  localparam logic [6:0]  CH_STATUS = 7'd127;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  cpu_chan;
  logic [31:0] wr_data;
  logic        wr_valid;
  logic [63:0] c2f_data;
  logic        c2f_valid;
  logic        f2c_ready;
  logic        f2c_reset;

  logic        wr_ready_a, rd_valid_a, f2c_valid_a;
  logic [31:0] rd_a;
  logic [63:0] f2c_data_a;
  logic        wr_ready_b, rd_valid_b, f2c_valid_b;
  logic [31:0] rd_b;
  logic [63:0] f2c_data_b;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [6:0]  ch;
    logic [31:0] wd;
    bit          wr;
    logic [31:0] exp;
  } reg_vec_t;

  reg_vec_t vecs[12];

  // reference model state
  logic [31:0] m_scr [120];
  logic [63:0] m_sum, m_xor, m_lfsr;
  logic [31:0] m_count, m_sent, m_idx;
  logic        m_mode;

  always #50 clk = ~clk;

  dma_app_core u_dut (
    .pcieClk_in(clk), .reset_in(rst), .cpuChan_in(cpu_chan), .cpuWrData_in(wr_data),
    .cpuWrValid_in(wr_valid), .cpuWrReady_out(wr_ready_a), .cpuRdData_out(rd_a),
    .cpuRdValid_out(rd_valid_a), .c2fData_in(c2f_data), .c2fValid_in(c2f_valid),
    .f2cData_out(f2c_data_a), .f2cValid_out(f2c_valid_a), .f2cReady_in(f2c_ready),
    .f2cReset_in(f2c_reset)
  );

  dma_app_core #(.EN_SWAP(1'b1), .CKSUM_XOR(1'b1)) u_dut_alt (
    .pcieClk_in(clk), .reset_in(rst), .cpuChan_in(cpu_chan), .cpuWrData_in(wr_data),
    .cpuWrValid_in(wr_valid), .cpuWrReady_out(wr_ready_b), .cpuRdData_out(rd_b),
    .cpuRdValid_out(rd_valid_b), .c2fData_in(c2f_data), .c2fValid_in(c2f_valid),
    .f2cData_out(f2c_data_b), .f2cValid_out(f2c_valid_b), .f2cReady_in(f2c_ready),
    .f2cReset_in(f2c_reset)
  );

  function automatic logic [31:0] swap16(input logic [31:0] d);
    return {d[15:0], d[31:16]};
  endfunction

  // Galois step from the tap list 64,63,61,60
  function automatic logic [63:0] lfsr_step(input logic [63:0] s);
    int          taps [4] = '{64, 63, 61, 60};
    logic [63:0] poly = '0;
    for (int k = 0; k < 4; k++) poly[taps[k]-1] = 1'b1;
    return s[0] ? ((s >> 1) ^ poly) : (s >> 1);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #10;
  endtask

  task automatic wr(input logic [6:0] ch, input logic [31:0] d);
    cpu_chan = ch;
    wr_data  = d;
    wr_valid = 1'b1;
    cyc();
    wr_valid = 1'b0;
  endtask

  task automatic rdchk(input string name, input logic [6:0] ch,
                       input logic [31:0] e_main, input logic [31:0] e_alt);
    cpu_chan = ch;
    #1;
    chk(name, 64'(rd_a), 64'(e_main));
    chk({name, "_alt"}, 64'(rd_b), 64'(swap16(e_alt)));
  endtask

  initial begin
    #20_000_000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] pat [6];
    logic [63:0] exp_w;
    rst = 1'b1; cpu_chan = '0; wr_data = '0; wr_valid = 1'b0;
    c2f_data = '0; c2f_valid = 1'b0; f2c_ready = 1'b0; f2c_reset = 1'b0;

    vecs[0]  = '{7'd3,   32'h12345678, 1'b1, 32'h12345678};
    vecs[1]  = '{7'd0,   32'hDEADBEEF, 1'b1, 32'hDEADBEEF};
    vecs[2]  = '{7'd119, 32'hA5A50F0F, 1'b1, 32'hA5A50F0F};
    vecs[3]  = '{7'd3,   32'h0,        1'b0, 32'h12345678};
    vecs[4]  = '{7'd126, 32'hFFFFFFFF, 1'b1, 32'hDA7A0002};
    vecs[5]  = '{7'd127, 32'h3,        1'b1, 32'h0};
    vecs[6]  = '{7'd122, 32'h55,       1'b1, 32'h0};
    vecs[7]  = '{7'd121, 32'h10,       1'b1, 32'h10};
    vecs[8]  = '{7'd121, 32'h0,        1'b1, 32'h0};
    vecs[9]  = '{7'd120, 32'h6,        1'b1, 32'h2};
    vecs[10] = '{7'd120, 32'h0,        1'b1, 32'h0};
    vecs[11] = '{7'd123, 32'hAAAA,     1'b1, 32'h0};

    // power-on reset
    cyc(); cyc();
    chk("rst_valid", 64'(f2c_valid_a), 64'd0);
    chk("rst_data", f2c_data_a, 64'd0);
    rdchk("rst_status", CH_STATUS, 32'd0, 32'd0);
    rdchk("rst_id", 7'd126, 32'hDA7A0002, 32'hDA7A0002);
    rst = 1'b0;
    cyc();

    // register map vectors
    for (int i = 0; i < 12; i++) begin
      if (vecs[i].wr) wr(vecs[i].ch, vecs[i].wd);
      rdchk($sformatf("regvec%0d", i), vecs[i].ch, vecs[i].exp, vecs[i].exp);
    end

    // checksum: add vs XOR
    c2f_valid = 1'b1;
    c2f_data = 64'h1;                  cyc();
    c2f_data = 64'hFFFFFFFFFFFFFFFF;   cyc();
    c2f_data = 64'h5;                  cyc();
    c2f_valid = 1'b0;
    rdchk("ck_lsw", CH_LSW, 32'h5, 32'hFFFFFFFB);
    rdchk("ck_msw", CH_MSW, 32'h0, 32'hFFFFFFFF);
    rdchk("ck_count", CH_COUNT, 32'd3, 32'd3);

    // clear beats a coincident C2F word
    c2f_valid = 1'b1; c2f_data = 64'h7;
    wr(CH_CTRL, 32'h4);
    c2f_valid = 1'b0;
    rdchk("clr_lsw", CH_LSW, 32'h0, 32'h0);
    rdchk("clr_msw", CH_MSW, 32'h0, 32'h0);
    rdchk("clr_count", CH_COUNT, 32'h0, 32'h0);
    c2f_valid = 1'b1; c2f_data = 64'h1_0000_0009; cyc(); c2f_valid = 1'b0;
    rdchk("post_clr_lsw", CH_LSW, 32'h9, 32'h9);
    rdchk("post_clr_msw", CH_MSW, 32'h1, 32'h1);
    rdchk("post_clr_count", CH_COUNT, 32'h1, 32'h1);
    wr(CH_CTRL, 32'h4);

    // counter burst of 4 with stalls
    pat = '{1, 0, 1, 1, 0, 1};
    wr(CH_LIMIT, 32'd4);
    wr(CH_CTRL, 32'h1);
    chk("burst_valid_lag", 64'(f2c_valid_a), 64'd0);
    cyc();
    exp_w = 64'd0;
    for (int i = 0; i < 6; i++) begin
      f2c_ready = pat[i][0];
      #1;
      chk($sformatf("burst_valid%0d", i), 64'(f2c_valid_a), 64'd1);
      chk($sformatf("burst_data%0d", i), f2c_data_a, exp_w);
      if (pat[i][0]) exp_w++;
      cyc();
    end
    f2c_ready = 1'b0;
    chk("burst_done_valid", 64'(f2c_valid_a), 64'd0);
    rdchk("burst_status", CH_STATUS, 32'd2, 32'd2);
    rdchk("burst_sent", CH_SENT, 32'd4, 32'd4);
    wr(CH_CTRL, 32'h0);
    cyc();
    rdchk("burst_idle", CH_STATUS, 32'd0, 32'd0);

    // LFSR mode and restart pulse
    wr(CH_LIMIT, 32'd0);
    wr(CH_CTRL, 32'h4);
    wr(CH_CTRL, 32'h3);
    cyc();
    m_lfsr = SEED;
    for (int i = 0; i < 5; i++) begin
      f2c_ready = 1'b1;
      #1;
      chk($sformatf("lfsr_word%0d", i), f2c_data_a, m_lfsr);
      m_lfsr = lfsr_step(m_lfsr);
      cyc();
    end
    f2c_ready = 1'b0; f2c_reset = 1'b1;
    cyc();
    f2c_reset = 1'b0;
    #1;
    chk("rs_data", f2c_data_a, SEED);
    chk("rs_valid", 64'(f2c_valid_a), 64'd1);
    rdchk("rs_sent", CH_SENT, 32'd0, 32'd0);
    rdchk("rs_status", CH_STATUS, 32'd1, 32'd1);
    f2c_ready = 1'b1;
    cyc();
    f2c_ready = 1'b0;
    #1;
    chk("rs_next", f2c_data_a, lfsr_step(SEED));

    // asynchronous reset in the middle of an LFSR burst
    f2c_ready = 1'b1;
    cyc(); cyc();
    #1;
    rst = 1'b1;
    #1;
    chk("async_valid", 64'(f2c_valid_a), 64'd0);
    chk("async_data", f2c_data_a, 64'd0);
    chk("async_valid_alt", 64'(f2c_valid_b), 64'd0);
    rdchk("async_status", CH_STATUS, 32'd0, 32'd0);
    rdchk("async_scratch", 7'd3, 32'd0, 32'd0);
    f2c_ready = 1'b0;
    cyc();
    rst = 1'b0;

    // randomized run against the reference model
    for (int i = 0; i < 120; i++) m_scr[i] = '0;
    m_sum = '0; m_xor = '0; m_count = '0; m_sent = '0; m_idx = '0;
    m_lfsr = SEED; m_mode = 1'($urandom_range(0, 1));
    wr(CH_CTRL, {30'd0, m_mode, 1'b1});
    cyc();
    for (int i = 0; i < 300; i++) begin
      int          act;
      logic [6:0]  ch;
      logic [31:0] d;
      logic        nmode;
      act = int'($urandom_range(0, 7));
      ch  = 7'($urandom_range(0, 119));
      d   = $urandom;
      nmode = 1'($urandom_range(0, 1));
      c2f_valid = 1'($urandom_range(0, 1));
      c2f_data  = {$urandom, $urandom};
      f2c_ready = 1'($urandom_range(0, 1));
      cpu_chan  = (act == 1) ? CH_CTRL : ch;
      wr_data   = (act == 1) ? {30'd0, nmode, 1'b1} : d;
      wr_valid  = (act <= 1);
      #1;
      exp_w = m_mode ? m_lfsr : {32'd0, m_idx};
      chk($sformatf("rnd_valid%0d", i), 64'(f2c_valid_a), 64'd1);
      chk($sformatf("rnd_data%0d", i), f2c_data_a, exp_w);
      if (act > 1) rdchk($sformatf("rnd_rd%0d", i), ch, m_scr[ch], m_scr[ch]);
      if (c2f_valid) begin
        m_sum += c2f_data;
        m_xor ^= c2f_data;
        m_count++;
      end
      if (f2c_ready) begin
        m_idx++;
        m_sent++;
        m_lfsr = lfsr_step(m_lfsr);
      end
      if (act == 0) m_scr[ch] = d;
      if (act == 1) m_mode = nmode;
      cyc();
      wr_valid = 1'b0;
    end
    c2f_valid = 1'b0; f2c_ready = 1'b0;
    rdchk("rnd_lsw", CH_LSW, m_sum[31:0], m_xor[31:0]);
    rdchk("rnd_msw", CH_MSW, m_sum[63:32], m_xor[63:32]);
    rdchk("rnd_count", CH_COUNT, m_count, m_count);
    rdchk("rnd_sent", CH_SENT, m_sent, m_sent);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
